multi_cycle_chunk_adder: RTL and testbench

MULTI_CYCLE_CHUNK_ADDER -- requirements
Module: multi_cycle_chunk_adder

---
 rtl/multi_cycle_chunk_adder.sv | 130 +++++++++++++
 tb/tb_multi_cycle_chunk_adder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/multi_cycle_chunk_adder.sv
// Multi-cycle adder: CHUNK bits per clock, N = WIDTH/CHUNK cycles per operation.
// Define CHUNK_ADDER_SUB_EN to enable subtraction through the sub input.
module multi_cycle_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             last;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             carry;
  logic             cy;
  logic [CHUNK-1:0] ps;
  logic [IW-1:0]    idx;

`ifdef CHUNK_ADDER_SUB_EN
  // Two's-complement subtract: invert b and force the carry-in to 1.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : c_in;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff      = b;
  assign cin_eff    = c_in;
`endif

  assign last = (idx == IW'(N - 1));

  // One chunk of the ripple per cycle; upper chunks of acc fill in as idx advances.
  always_comb begin
    {cy, ps} = {1'b0, a_q[idx*CHUNK +: CHUNK]} + {1'b0, b_q[idx*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, carry};
    acc_nxt = acc;
    acc_nxt[idx*CHUNK +: CHUNK] = ps;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake: start is sampled only while idle or during the done cycle;
  // the done cycle is the earliest point a back-to-back operation can begin.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      a_q   <= a;
      b_q   <= b_eff;
      carry <= cin_eff;
      idx   <= '0;
    end else if (state == RUN) begin
      acc   <= acc_nxt;
      carry <= cy;
      idx   <= last ? '0 : idx + IW'(1);
      if (last) begin
        sum      <= acc_nxt;
        c_out    <= cy;
        overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_nxt[WIDTH-1] != a_q[WIDTH-1]);
      end
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_multi_cycle_chunk_adder.sv
// Bench for multi_cycle_chunk_adder (WIDTH=16, CHUNK=4): directed vectors,
// expected-result queue, monitor that checks every done pulse.
module tb_multi_cycle_chunk_adder;
  localparam int W = 16;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;
  logic [1:0]   dbg_state;

  logic [W+1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  multi_cycle_chunk_adder #(.WIDTH(W), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: act=0x%0h req=0x%0h", name, act, req);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && done) begin
      chk("exp_available", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        chk("sum", 32'(sum), 32'(e[W+1:2]));
        chk("c_out", 32'(c_out), 32'(e[1]));
        chk("overflow", 32'(overflow), 32'(e[0]));
      end
    end
  end

  // Caller is at a negedge; start is sampled at the next rising edge (edge k).
  // Returns at the negedge on which done is seen (after edge k+N).
  task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                       input logic vs, input logic [W-1:0] es, input logic ec,
                       input logic eo, input logic inject);
    int busy_cnt = 0;
    int lat = -1;
    a = va; b = vb; c_in = vc; sub = vs; start = 1'b1;
    exp_q.push_back({es, ec, eo});
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (j == 0) begin
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
      end
      if (inject && j == 1) begin
        a = 16'h1234; b = 16'h1111; start = 1'b1;
      end
      if (inject && j == 2) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        lat = j;
        break;
      end
    end
    chk("done_latency", 32'(lat), 32'(N));
    chk("busy_cycles", 32'(busy_cnt), 32'(N));
  endtask

  // driver
  initial begin
    int done_seen;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("idle_after_done", 32'(busy | done), 32'd0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    do_op(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
`ifdef CHUNK_ADDER_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
`else
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h000D, 1'b0, 1'b0, 1'b0);
`endif
    @(negedge clk);
    // ignored mid-run start, then back-to-back start during the done cycle
    do_op(16'h1357, 16'h2468, 1'b0, 1'b0, 16'h37BF, 1'b0, 1'b0, 1'b1);
    do_op(16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // asynchronous reset in the middle of a run
    a = 16'h00FF; b = 16'h0001; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    chk("async_sum", 32'(sum), 32'd0);
    chk("async_c_out", 32'(c_out), 32'd0);
    chk("async_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    chk("no_done_after_rst", 32'(done_seen), 32'd0);
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
